// File: rtl/gray_frame_writer.sv
// RGB565 pixel stream to 8-bit gray frame-RAM writer.
// Frame-gated capture (single-shot or continuous) with optional 2x2 decimation.
module gray_frame_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DECIM    = 0,
    parameter int AW       = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   pix_data,
    input  logic          pix_valid,
    input  logic          href,
    input  logic          vsync,
    input  logic          gray_en,
    input  logic          mode_cont,
    input  logic          cap_req,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_short,
    output logic [7:0]    frame_cnt
);

    localparam int EXP = (DECIM != 0) ? (H_ACTIVE / 2) * (V_ACTIVE / 2)
                                      : H_ACTIVE * V_ACTIVE;
    localparam int XW  = $clog2(H_ACTIVE + 1);
    localparam int YW  = $clog2(V_ACTIVE + 1);
    localparam int CW  = $clog2(EXP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t        r_state;
    logic          r_vs;
    logic          r_href;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_acc;
    logic          r_drain;
    logic [AW-1:0] r_addr;

    logic          r_s1_v;
    logic          r_s1_ge;
    logic [7:0]    r_s1_r;
    logic [7:0]    r_s1_g;
    logic [7:0]    r_s1_b;

    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          r_done;
    logic          r_short;
    logic [7:0]    r_cnt;

    logic          w_vs_fall;
    logic          w_vs_rise;
    logic          w_href_fall;
    logic          w_phase_ok;
    logic          w_accept;
    logic [CW-1:0] w_acc_next;
    logic          w_last;
    logic [15:0]   w_sum;
    logic [7:0]    w_luma;

    assign w_vs_fall   = r_vs & ~vsync;
    assign w_vs_rise   = ~r_vs & vsync;
    assign w_href_fall = r_href & ~href;

    assign w_phase_ok = (DECIM == 0) | (~r_x[0] & ~r_y[0]);

    assign w_accept = (r_state == S_CAPTURE) & pix_valid & href
                    & (r_x < XW'(H_ACTIVE)) & (r_y < YW'(V_ACTIVE))
                    & w_phase_ok;

    assign w_acc_next = r_acc + CW'(1);
    assign w_last     = w_accept & (w_acc_next == CW'(EXP));

    // Weights sum to 256, so full-scale white lands exactly on 0xFF00.
    assign w_sum  = 16'd77  * {8'd0, r_s1_r}
                  + 16'd150 * {8'd0, r_s1_g}
                  + 16'd29  * {8'd0, r_s1_b};
    assign w_luma = 8'(w_sum >> 8);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_vs      <= 1'b0;
            r_href    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_acc     <= '0;
            r_drain   <= 1'b0;
            r_addr    <= '0;
            r_s1_v    <= 1'b0;
            r_s1_ge   <= 1'b0;
            r_s1_r    <= '0;
            r_s1_g    <= '0;
            r_s1_b    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_short   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_vs   <= vsync;
            r_href <= href;
            r_done <= 1'b0;

            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_r  <= {pix_data[15:11], pix_data[15:13]};
                r_s1_g  <= {pix_data[10:5], pix_data[10:9]};
                r_s1_b  <= {pix_data[4:0], pix_data[4:2]};
                r_s1_ge <= gray_en;
            end

            r_wr_en <= r_s1_v;
            if (r_s1_v) begin
                r_wr_data <= r_s1_ge ? w_luma : r_s1_g;
                r_wr_addr <= r_addr;
                r_addr    <= r_addr + AW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (mode_cont | cap_req)
                        r_state <= S_WAIT_VS;
                end
                S_WAIT_VS: begin
                    if (w_vs_fall) begin
                        r_state   <= S_CAPTURE;
                        r_x       <= '0;
                        r_y       <= '0;
                        r_acc     <= '0;
                        r_addr    <= '0;
                        r_wr_addr <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_href_fall) begin
                        r_x <= '0;
                        if (r_y != YW'(V_ACTIVE))
                            r_y <= r_y + YW'(1);
                    end else if (pix_valid & href
                                 & (r_x != XW'(H_ACTIVE))) begin
                        r_x <= r_x + XW'(1);
                    end
                    if (w_accept)
                        r_acc <= w_acc_next;
                    if (w_vs_rise | w_last) begin
                        r_state <= S_DRAIN;
                        r_drain <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Two cycles flush the accepts still in the pipeline.
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state <= mode_cont ? S_WAIT_VS : S_IDLE;
                        r_done  <= 1'b1;
                        r_short <= (r_acc != CW'(EXP));
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_done;
    assign frame_short = r_short;
    assign frame_cnt   = r_cnt;

endmodule
